i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
- Shares one byte-level I2C master between NUM_CLIENTS sensor controllers (BMP180 query FSM and peers).
- Grants whole transactions round-robin and muxes start/send/receive/datasend from the owner to the master.
- Routes isReady/sended/received back to the owner only; non-owners see an idle bus.
- A watchdog revokes a grant whose owner stalls the master.

Parameters:
NUM_CLIENTS, 4, number of requesters (2..8)
IDX_W, 2, owner index width, ceil(log2(NUM_CLIENTS))
TIMEOUT_W, 16, watchdog counter width
TIMEOUT_MAX, 16'hFFFF, idle cycles in GRANT before revocation

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
req  in  NUM_CLIENTS  per-client bus request, held for the whole transaction
gnt  out  NUM_CLIENTS  one-hot grant
cli_start  in  NUM_CLIENTS  per-client start
cli_send  in  NUM_CLIENTS  per-client send
cli_receive  in  NUM_CLIENTS  per-client receive
cli_datasend  in  8*NUM_CLIENTS  per-client byte; client k on bits [8k+7:8k]
cli_isReady  out  NUM_CLIENTS  master ready, owner only
cli_sended  out  NUM_CLIENTS  master sended, owner only
cli_received  out  NUM_CLIENTS  master received, owner only
cli_datareceive  out  8  master received byte, broadcast
m_isReady  in  1  master idle
m_start  out  1  to master
m_send  out  1  to master
m_receive  out  1  to master
m_datasend  out  8  to master
m_sended  in  1  master byte-sent toggle/level
m_received  in  1  master byte-received toggle/level
m_datareceive  in  8  master received byte
owner  out  IDX_W  current/last owner index
timeout  out  1  one-cycle pulse on watchdog revocation

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, gnt=0, owner=0, last=NUM_CLIENTS-1, timeout=0, watchdog=0, lockout=0.
- Reset outputs: m_start=m_send=m_receive=0, m_datasend=8'h00; all cli_* outputs except cli_datareceive are 0.
- Reset mid-transaction drops all master controls to 0 immediately, with no clock required.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - Eligible set is req & ~lockout.
  - If m_isReady=1 and the eligible set is non-empty, pick the first eligible index after last, wrapping modulo NUM_CLIENTS.
  - Register owner, set gnt[owner] and go to GRANT.
  - Latency: req at edge t gives gnt at edge t+1.
  - Master outputs are held at 0 in IDLE.
- GRANT:
  - Master outputs are combinational copies of the owner's cli_* inputs.
  - cli_isReady/sended/received[owner] equal the master signals; all other clients read 0.
  - req[owner]=0 → RELEASE, gnt=0 next edge, last<=owner.
  - Watchdog clears on any change of m_sended or m_received versus the previous cycle.
  - Otherwise the watchdog increments by 1, saturating.
  - Watchdog reaches TIMEOUT_MAX with req[owner] still 1 → RELEASE, gnt=0, timeout=1 for exactly one cycle, lockout[owner]=1, last<=owner.
  - req drop and watchdog expiry in the same cycle count as a normal release: no timeout pulse, no lockout.
- RELEASE:
  - Master outputs are forced to 0.
  - Stay until m_isReady=1, then go to IDLE.
  - This guarantees at least one idle cycle between owners, so no glitched start reaches the master.
- Lockout: lockout[k] clears when req[k] is observed 0. A revoked client must drop req before it can win again.
- Requests arriving during GRANT/RELEASE are queued by level only; they are not latched.
- The watchdog is cleared on entry to GRANT.
- owner holds its value in IDLE/RELEASE (last owner) for debug.
- Width rules:
  - Index arithmetic wraps modulo NUM_CLIENTS, not 2^IDX_W.
  - The watchdog is TIMEOUT_W wide and never wraps.

Decomposition:
- Shared package i2c_arb_pkg:
  - state encoding (IDLE/GRANT/RELEASE)
  - NULL_8
  - default TIMEOUT_MAX
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: request vector and last index.
  - Outputs: valid flag and winner index.
  - Reused by later shared-resource arbiters.

Test Plan:
1. Single client: req[0]=1 with m_isReady=1 → gnt=4'b0001 one edge later, owner=0. Drive cli_datasend[7:0]=8'hEE with cli_start[0]=1 → m_datasend=8'hEE, m_start=1. Drop req → gnt=0, m_* =0.
2. Round-robin fairness: req=4'b1111 held, each owner drops req after 3 cycles and re-raises it → grant order 0,1,2,3,0. At least one cycle with gnt=0 between owners.
3. Isolation: owner 2 transferring, m_sended toggles → only cli_sended[2] follows. cli_sended[0,1,3]=0. cli_datareceive equals m_datareceive for all clients.
4. Watchdog: TIMEOUT_MAX=16, owner 1 holds req with no m_sended/m_received activity → after 16 GRANT cycles gnt=0 and timeout pulses once. req[1] still high → no re-grant. Drop then raise req[1] → granted again.
5. Busy master: m_isReady=0 with req pending → gnt stays 0. In RELEASE with m_isReady=0 → stays in RELEASE. Raise m_isReady → grant one edge after IDLE is reached.
6. Async reset mid-GRANT with m_send=1 → m_send=0 and gnt=0 immediately on reset low, before any clock edge. After release from reset, the first grant goes to client 0 when all request.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter family.
// State encoding, null byte and default watchdog limit.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_e;

  localparam logic [7:0]  NULL_8          = 8'h00;
  localparam logic [15:0] TIMEOUT_MAX_DEF = 16'hFFFF;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last,
// wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int k;
    k       = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last_i) + i) % N;
      if (!valid_o && req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of one byte-level I2C master shared by several
// sensor controllers, with a stall watchdog and per-client lockout.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int                   NUM_CLIENTS = 4,
  parameter int                   IDX_W       = 2,
  parameter int                   TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_MAX_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CLIENTS-1:0]   req,
  output logic [NUM_CLIENTS-1:0]   gnt,
  input  logic [NUM_CLIENTS-1:0]   cli_start,
  input  logic [NUM_CLIENTS-1:0]   cli_send,
  input  logic [NUM_CLIENTS-1:0]   cli_receive,
  input  logic [8*NUM_CLIENTS-1:0] cli_datasend,
  output logic [NUM_CLIENTS-1:0]   cli_isReady,
  output logic [NUM_CLIENTS-1:0]   cli_sended,
  output logic [NUM_CLIENTS-1:0]   cli_received,
  output logic [7:0]               cli_datareceive,
  input  logic                     m_isReady,
  output logic                     m_start,
  output logic                     m_send,
  output logic                     m_receive,
  output logic [7:0]               m_datasend,
  input  logic                     m_sended,
  input  logic                     m_received,
  input  logic [7:0]               m_datareceive,
  output logic [IDX_W-1:0]         owner,
  output logic                     timeout
);

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic [NUM_CLIENTS-1:0] lock_q, lock_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d, wdog_inc;
  logic                   timeout_q, timeout_d;
  logic                   sended_q, received_q;
  logic                   pick_valid, activity, in_grant;
  logic [IDX_W-1:0]       pick_idx;

  rr_pick #(
    .N    (NUM_CLIENTS),
    .IDX_W(IDX_W)
  ) u_pick (
    .req_i  (req & ~lock_q),
    .last_i (last_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  assign activity = (m_sended != sended_q) | (m_received != received_q);
  assign wdog_inc = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    lock_d    = lock_q & req;
    unique case (state_q)
      ST_IDLE: begin
        if (m_isReady && pick_valid) begin
          owner_d = pick_idx;
          gnt_d   = NUM_CLIENTS'(1) << pick_idx;
          wdog_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[owner_q]) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          last_d  = owner_q;
        end else if (activity) begin
          wdog_d = '0;
        end else begin
          wdog_d = wdog_inc;
          // Stalled owner: revoke and lock out until it drops req.
          if (wdog_inc >= TIMEOUT_MAX) begin
            state_d         = ST_RELEASE;
            gnt_d           = '0;
            last_d          = owner_q;
            timeout_d       = 1'b1;
            lock_d[owner_q] = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (m_isReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      lock_q     <= '0;
      owner_q    <= '0;
      last_q     <= IDX_W'(NUM_CLIENTS - 1);
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
      sended_q   <= 1'b0;
      received_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
      sended_q   <= m_sended;
      received_q <= m_received;
    end
  end

  assign in_grant = (state_q == ST_GRANT);

  assign m_start    = in_grant & cli_start[owner_q];
  assign m_send     = in_grant & cli_send[owner_q];
  assign m_receive  = in_grant & cli_receive[owner_q];
  assign m_datasend = in_grant ? cli_datasend[8*owner_q +: 8] : NULL_8;

  assign cli_isReady  = in_grant ? (NUM_CLIENTS'(m_isReady) << owner_q) : '0;
  assign cli_sended   = in_grant ? (NUM_CLIENTS'(m_sended) << owner_q) : '0;
  assign cli_received = in_grant ? (NUM_CLIENTS'(m_received) << owner_q) : '0;

  assign cli_datareceive = m_datareceive;
  assign gnt             = gnt_q;
  assign owner           = owner_q;
  assign timeout         = timeout_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: reference model plus directed scenarios.
// Four clients, watchdog limit shortened to 16.
module tb_i2c_bus_arbiter;

  localparam int N    = 4;
  localparam int TMAX = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, gnt;
  logic [N-1:0] cli_start, cli_send, cli_receive;
  logic [8*N-1:0] cli_datasend;
  logic [N-1:0] cli_isReady, cli_sended, cli_received;
  logic [7:0]   cli_datareceive;
  logic         m_isReady, m_start, m_send, m_receive;
  logic [7:0]   m_datasend, m_datareceive;
  logic         m_sended, m_received;
  logic [1:0]   owner;
  logic         timeout;

  int n_chk  = 0;
  int n_fail = 0;

  i2c_bus_arbiter #(
    .NUM_CLIENTS(N),
    .IDX_W      (2),
    .TIMEOUT_W  (16),
    .TIMEOUT_MAX(16'd16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .gnt            (gnt),
    .cli_start      (cli_start),
    .cli_send       (cli_send),
    .cli_receive    (cli_receive),
    .cli_datasend   (cli_datasend),
    .cli_isReady    (cli_isReady),
    .cli_sended     (cli_sended),
    .cli_received   (cli_received),
    .cli_datareceive(cli_datareceive),
    .m_isReady      (m_isReady),
    .m_start        (m_start),
    .m_send         (m_send),
    .m_receive      (m_receive),
    .m_datasend     (m_datasend),
    .m_sended       (m_sended),
    .m_received     (m_received),
    .m_datareceive  (m_datareceive),
    .owner          (owner),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who holds the bus, who is draining, who is locked out.
  bit         mdl_busy, mdl_drain, mdl_to;
  int         mdl_own, mdl_last, mdl_idle;
  bit [N-1:0] mdl_lock;
  logic       mdl_ps, mdl_pr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_busy = 0; mdl_drain = 0; mdl_to = 0;
      mdl_own = 0; mdl_last = N - 1; mdl_idle = 0;
      mdl_lock = '0; mdl_ps = 0; mdl_pr = 0;
    end else begin
      bit [N-1:0] lk;
      lk = mdl_lock & req;
      mdl_to = 0;
      if (mdl_busy) begin
        if (!req[mdl_own]) begin
          mdl_busy = 0; mdl_drain = 1; mdl_last = mdl_own;
        end else if (m_sended != mdl_ps || m_received != mdl_pr) begin
          mdl_idle = 0;
        end else begin
          mdl_idle++;
          if (mdl_idle >= TMAX) begin
            mdl_busy = 0; mdl_drain = 1; mdl_last = mdl_own;
            mdl_to = 1; lk[mdl_own] = 1'b1;
          end
        end
      end else if (mdl_drain) begin
        if (m_isReady) mdl_drain = 0;
      end else if (m_isReady) begin
        for (int off = 1; off <= N; off++) begin
          int k;
          k = (mdl_last + off) % N;
          if (req[k] && !mdl_lock[k]) begin
            mdl_own = k; mdl_busy = 1; mdl_idle = 0;
            break;
          end
        end
      end
      mdl_lock = lk;
      mdl_ps = m_sended;
      mdl_pr = m_received;
    end
  end

  int          order[$];
  logic [N-1:0] prev_gnt = '0;
  int          to_cnt = 0;

  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = mdl_busy ? N'(1) << mdl_own : '0;
    chk("gnt", gnt, eg);
    chk("owner", owner, mdl_own);
    chk("timeout", timeout, mdl_to);
    chk("m_start", m_start, mdl_busy & cli_start[mdl_own]);
    chk("m_send", m_send, mdl_busy & cli_send[mdl_own]);
    chk("m_receive", m_receive, mdl_busy & cli_receive[mdl_own]);
    chk("m_datasend", m_datasend,
        mdl_busy ? cli_datasend[8*mdl_own +: 8] : 8'h00);
    chk("cli_isReady", cli_isReady, m_isReady ? eg : '0);
    chk("cli_sended", cli_sended, m_sended ? eg : '0);
    chk("cli_received", cli_received, m_received ? eg : '0);
    chk("cli_datareceive", cli_datareceive, m_datareceive);
    if (prev_gnt != 0 && gnt != 0 && prev_gnt != gnt)
      chk("gap", 0, 1);
    if (gnt != 0 && prev_gnt == 0) order.push_back(int'(owner));
    if (timeout) to_cnt++;
    prev_gnt = gnt;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(input string nm);
    int i;
    i = 0;
    while (gnt == 0 && i < 30) begin
      step(1);
      i++;
    end
    chk(nm, (gnt != 0), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    int cnt, o;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset = 0; req = 0; cli_start = 0; cli_send = 0; cli_receive = 0;
    cli_datasend = 0; m_isReady = 1; m_sended = 0; m_received = 0;
    m_datareceive = 8'h00;
    step(2);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_owner", owner, 0);
    chk("rst_m_datasend", m_datasend, 8'h00);
    reset = 1;
    step(1);

    // single client
    req = 4'b0001;
    step(1);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_owner", owner, 0);
    cli_datasend[7:0] = 8'hEE; cli_start = 4'b0001;
    #1;
    chk("t1_mdata", m_datasend, 8'hEE);
    chk("t1_mstart", m_start, 1);
    step(2);
    req = 0;
    step(1);
    chk("t1_rel_gnt", gnt, 4'b0000);
    chk("t1_rel_mstart", m_start, 0);
    chk("t1_rel_mdata", m_datasend, 8'h00);
    cli_start = 0;
    step(2);

    // round robin from a fresh reset
    do_reset();
    order.delete();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt("t2_wait");
      o = int'(owner);
      step(3);
      req[o] = 1'b0;
      step(1);
      req[o] = 1'b1;
    end
    req = 0;
    step(4);
    chk("t2_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk("t2_order", order[i], exp_order[i]);

    // isolation
    req = 4'b0100; m_datareceive = 8'h5A;
    wait_gnt("t3_wait");
    chk("t3_owner", owner, 2);
    for (int i = 0; i < 4; i++) begin
      m_sended = ~m_sended;
      #1;
      chk("t3_sended", cli_sended, m_sended ? 4'b0100 : 4'b0000);
      step(1);
    end
    m_received = 1;
    #1;
    chk("t3_received", cli_received, 4'b0100);
    chk("t3_drx", cli_datareceive, 8'h5A);
    step(1);
    req = 0;
    step(4);

    // watchdog revocation and lockout
    to_cnt = 0;
    req = 4'b0010;
    wait_gnt("t4_wait");
    cnt = 1;
    for (int i = 0; i < 40 && gnt != 0; i++) begin
      step(1);
      if (gnt != 0) cnt++;
    end
    chk("t4_cycles", cnt, TMAX);
    step(10);
    chk("t4_to_pulses", to_cnt, 1);
    chk("t4_locked_gnt", gnt, 4'b0000);
    req = 0;
    step(1);
    req = 4'b0010;
    wait_gnt("t4_regrant");
    chk("t4_owner", owner, 1);
    req = 0;
    step(4);

    // busy master
    m_isReady = 0; req = 4'b0001;
    step(4);
    chk("t5_busy_gnt", gnt, 4'b0000);
    m_isReady = 1;
    step(1);
    chk("t5_gnt", gnt, 4'b0001);
    m_isReady = 0; req = 0;
    step(3);
    req = 4'b0010;
    step(3);
    chk("t5_rel_hold", gnt, 4'b0000);
    m_isReady = 1;
    step(1);
    chk("t5_idle", gnt, 4'b0000);
    step(1);
    chk("t5_gnt2", gnt, 4'b0010);

    // async reset mid-grant
    cli_send = 4'b0010;
    #1;
    chk("t6_msend", m_send, 1);
    #1;
    reset = 0;
    #1;
    chk("t6_rst_msend", m_send, 0);
    chk("t6_rst_gnt", gnt, 4'b0000);
    step(1);
    req = 4'b1111; cli_send = 0;
    reset = 1;
    step(1);
    chk("t6_first", gnt, 4'b0001);
    req = 0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
